// File: rtl/uart_apb_bridge_pkg.sv
// Shared types and byte codes for the UART-to-APB command bridge.
package uart_apb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    SETUP,
    ACCESS,
    RESP,
    RDATA
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'

endpackage

// File: rtl/uart_apb_bridge_if.sv
// Byte-stream (rx/tx) and APB signal bundle. The bridge uses the master view;
// the environment (UART byte path plus APB slave) uses the slave view.
interface uart_apb_bridge_if #(
  parameter int APB_AW = 32
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              psel;
  logic              penable;
  logic [APB_AW-1:0] paddr;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  rx_data, rx_valid, tx_ready, prdata, pready, pslverr,
    output rx_ready, tx_data, tx_valid, psel, penable, paddr, pwrite, pwdata, pstrb
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, prdata, pready, pslverr,
    input  rx_ready, tx_data, tx_valid, psel, penable, paddr, pwrite, pwdata, pstrb
  );
endinterface

// File: rtl/uart_apb_bridge.sv
// UART byte-stream command decoder acting as APB master.
// 'W' a3 a2 a1 a0 d3 d2 d1 d0 -> APB write, reply 'K' (or 'E').
// 'R' a3 a2 a1 a0             -> APB read,  reply 'K' d3 d2 d1 d0 (or 'E').
// A stalled frame (no byte for TIMEOUT_CYC cycles) is dropped silently.
module uart_apb_bridge
  import uart_apb_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000,
  parameter int APB_AW      = 32
) (
  input  logic               clk,
  input  logic               rst,
  uart_apb_bridge_if.master  bus,
  output logic               busy,
  output logic               frame_timeout
);

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [APB_AW-1:0] paddr_q, paddr_d;
  logic [31:0]       pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tmo_pulse_q, tmo_pulse_d;

  logic rx_fire, tx_fire;

  // Input side is only open while collecting a frame; held closed in reset.
  assign bus.rx_ready = rst && (state_q inside {IDLE, ADDR, DATA});
  assign rx_fire      = bus.rx_valid && bus.rx_ready;
  assign tx_fire      = tx_valid_q && bus.tx_ready;

  // APB strobes decode straight from the state flop so reset kills them at once.
  assign bus.psel     = (state_q == SETUP) || (state_q == ACCESS);
  assign bus.penable  = (state_q == ACCESS);
  assign bus.paddr    = paddr_q;
  assign bus.pwrite   = pwrite_q;
  assign bus.pwdata   = pwdata_q;
  assign bus.pstrb    = 4'hF;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign busy          = (state_q != IDLE);
  assign frame_timeout = tmo_pulse_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmo_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      tmo_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      tmo_pulse_q <= tmo_pulse_d;
    end
  end

  // Next-state and datapath updates. rdata_q is shifted left as bytes go out,
  // so the next read byte is always rdata_q[31:24].
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    tmo_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_fire) begin
          if (bus.rx_data == CMD_WR || bus.rx_data == CMD_RD) begin
            state_d  = ADDR;
            pwrite_d = (bus.rx_data == CMD_WR);
            cnt_d    = '0;
            tmo_d    = '0;
            err_d    = 1'b0;
          end else begin
            state_d    = RESP;
            err_d      = 1'b1;
            tx_valid_d = 1'b1;
            tx_data_d  = RSP_ERR;
          end
        end
      end
      ADDR: begin
        if (rx_fire) begin
          paddr_d = APB_AW'({paddr_q, bus.rx_data});
          cnt_d   = cnt_q + 2'd1;
          tmo_d   = '0;
          if (cnt_q == 2'd3) state_d = pwrite_q ? DATA : SETUP;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = IDLE;
          tmo_pulse_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DATA: begin
        if (rx_fire) begin
          pwdata_d = {pwdata_q[23:0], bus.rx_data};
          cnt_d    = cnt_q + 2'd1;
          tmo_d    = '0;
          if (cnt_q == 2'd3) state_d = SETUP;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = IDLE;
          tmo_pulse_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (bus.pready) begin
          rdata_d    = bus.prdata;
          err_d      = bus.pslverr;
          tx_valid_d = 1'b1;
          tx_data_d  = bus.pslverr ? RSP_ERR : RSP_OK;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (tx_fire) begin
          if (!pwrite_q && !err_q) begin
            state_d   = RDATA;
            cnt_d     = '0;
            tx_data_d = rdata_q[31:24];
            rdata_d   = {rdata_q[23:0], 8'h00};
          end else begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
          end
        end
      end
      RDATA: begin
        if (tx_fire) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
          end else begin
            tx_data_d = rdata_q[31:24];
            rdata_d   = {rdata_q[23:0], 8'h00};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/uart_apb_bridge.md
Name: uart_apb_bridge

Overview:
- Byte-stream command decoder that sits between the UART receive/transmit byte interfaces and an APB bus, and acts as the APB master.
- Turns host command frames received over the UART into APB read/write transactions.
- Serializes the response bytes back to the UART transmitter.
- Gives a debug host access to the apbuart register map and other APB slaves without a CPU.

Parameters:
- TIMEOUT_CYC, 100000: idle clock cycles allowed between bytes inside a frame before the frame is aborted.
- APB_AW, 32: APB address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts the byte this cycle
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data
- psel  out  1  APB select
- penable  out  1  APB enable
- paddr  out  APB_AW  APB address
- pwrite  out  1  APB direction, 1 = write
- pwdata  out  32  APB write data
- pstrb  out  4  APB byte strobes, constant 4'hF
- prdata  in  32  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error
- busy  out  1  high whenever state is not IDLE
- frame_timeout  out  1  one-cycle pulse when a frame is aborted by the timeout

Behaviour:
- Frame formats, all multi-byte fields MSB first:
  - Write: 0x57 'W', 4 address bytes, 4 data bytes.
  - Read: 0x52 'R', 4 address bytes.
- Responses:
  - Write OK: 0x4B 'K'.
  - Read OK: 'K' followed by 4 data bytes.
  - Error (pslverr=1 or unknown command byte): 0x45 'E' only.
- A byte is accepted when rx_valid && rx_ready. A tx byte is consumed when tx_valid && tx_ready.
- rx_ready = 1 only in IDLE, ADDR and DATA, and is forced 0 while rst is low.
- tx_valid and tx_data are registered and held stable until the byte is consumed.
- State machine:
  - IDLE:
    - cmd 'W' or 'R' -> ADDR; latch pwrite = (cmd == 'W'); clear byte count.
    - Any other byte -> RESP, with err set.
  - ADDR: shift each byte into paddr. On the 4th byte -> DATA if write, else SETUP.
  - DATA: shift each byte into pwdata. On the 4th byte -> SETUP.
  - SETUP: psel=1, penable=0 for exactly one cycle -> ACCESS.
  - ACCESS:
    - psel=1, penable=1; hold until pready=1.
    - On pready: latch prdata into rdata_q and pslverr into err; drop psel/penable the next cycle; -> RESP.
  - RESP:
    - tx_data = err ? 'E' : 'K'.
    - On consume: -> RDATA if read && !err, else IDLE.
  - RDATA: send rdata_q[31:24], [23:16], [15:8], [7:0] in order, one byte per consume; after the 4th -> IDLE.
- Timeout:
  - A counter runs in ADDR and DATA only.
  - Cleared on each accepted byte and on entry to either state.
  - When it reaches TIMEOUT_CYC-1: -> IDLE, frame_timeout pulses for 1 cycle, no response is sent, APB is untouched.
  - No timeout in SETUP, ACCESS, RESP or RDATA; the APB slave and the transmitter are trusted to progress.
- paddr and pwdata are stable from SETUP through the ACCESS completion cycle.
- pwdata is unchanged (previous value) for reads.
- Reset values, all outputs:
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - tx_valid=0, tx_data=0, busy=0, frame_timeout=0, rx_ready=0.
  - State = IDLE.
- Reset asserted mid-transaction, including during ACCESS: all outputs are forced to reset values immediately; the interrupted frame is lost.
- Latency: the last write-data byte is accepted in cycle N -> psel=1 in N+1 and penable=1 in N+2. With pready=1 in N+2, tx_valid with 'K' is asserted in N+3.
- Bytes arriving in SETUP through RDATA are back-pressured (rx_ready=0), not dropped.

Decomposition:
- Package uart_apb_bridge_pkg holds:
  - state enum: IDLE, ADDR, DATA, SETUP, ACCESS, RESP, RDATA
  - command/response constants CMD_WR=8'h57, CMD_RD=8'h52, RSP_OK=8'h4B, RSP_ERR=8'h45
- Single module; no sub-module is warranted. The byte counter (2 bits) and the timeout counter ($clog2(TIMEOUT_CYC) bits) are inline.

Test Plan:
- Write: send 57 00 00 00 04 DE AD BE EF with tx_ready=1 and a slave with pready=1 -> one APB write with paddr=32'h4, pwdata=32'hDEADBEEF, pstrb=4'hF, SETUP then ACCESS each exactly 1 cycle; tx emits 4B.
- Read with wait states: send 52 00 00 00 08; slave returns pready after 3 cycles with prdata=32'h12345678 -> penable held 4 cycles; tx emits 4B 12 34 56 78 in order.
- Error paths:
  - Same read with pslverr=1 -> tx emits only 45.
  - Unknown byte 0x41 -> tx emits 45 and no APB activity.
- Timeout: send 57 00 00, then idle TIMEOUT_CYC cycles (TIMEOUT_CYC=50 in bench) -> frame_timeout pulses once, busy falls, no tx and no APB activity. A following valid frame completes normally.
- Back-pressure: hold tx_ready=0 for 20 cycles during a read response -> tx_data stays 4B, rx_ready=0 throughout, bytes are not lost once tx_ready returns.
- Reset mid-ACCESS: assert rst low while penable=1 -> psel, penable and tx_valid go 0 asynchronously. After release, busy=0 and rx_ready=1, and the next frame works.
